// File: rtl/atm_keypad_entry_if.sv
// Keypad entry <-> ATM controller signal bundle.
// master: the keypad entry block. slave: the controller / key source side.
interface atm_keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        req_ready;
  logic        req_valid;
  logic [3:0]  acc_num;
  logic [13:0] pin;
  logic [13:0] new_pin;
  logic [15:0] amount;
  logic [2:0]  operation;
  logic        language;
  logic        err;
  logic        timeout;
  logic [2:0]  entry_state;

  modport master (
    input  key_valid, key_code, req_ready,
    output req_valid, acc_num, pin, new_pin, amount, operation,
           language, err, timeout, entry_state
  );

  modport slave (
    output key_valid, key_code, req_ready,
    input  req_valid, acc_num, pin, new_pin, amount, operation,
           language, err, timeout, entry_state
  );
endinterface

// File: rtl/atm_keypad_entry.sv
// ATM keypad front-end: collects account, PIN, operation, amount and new PIN
// from key strobes and issues one transaction request with valid/ready.
module atm_keypad_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [2:0]  OP_BALANCE     = 3'd3,
  parameter logic [2:0]  OP_WITHDRAW    = 3'd4,
  parameter logic [2:0]  OP_DEPOSIT     = 3'd5,
  parameter logic [2:0]  OP_CHANGE_PIN  = 3'd6
) (
  input logic                 clk,
  input logic                 rst,
  atm_keypad_entry_if.master  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;
  localparam logic [3:0] KEY_LANG   = 4'hD;

  typedef enum logic [2:0] {
    S_ACC    = 3'd0,
    S_PIN    = 3'd1,
    S_OP     = 3'd2,
    S_AMT    = 3'd3,
    S_NEWPIN = 3'd4,
    S_ISSUE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    acc_q, acc_d;
  logic          acc_held_q, acc_held_d;
  logic [13:0]   pin_q, pin_d;
  logic [2:0]    pin_cnt_q, pin_cnt_d;
  logic [13:0]   newpin_q, newpin_d;
  logic [2:0]    newpin_cnt_q, newpin_cnt_d;
  logic [15:0]   amt_q, amt_d;
  logic [2:0]    op_key_q, op_key_d;   // 0 = none, 1..4 = menu key
  logic          lang_q, lang_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          is_digit;
  logic          clr_all;
  logic          timer_run;
  logic [19:0]   amt_ext;

  assign is_digit = (bus.key_code <= 4'd9);
  assign amt_ext  = ({4'd0, amt_q} * 20'd10) + {16'd0, bus.key_code};

  // Next-state, field accumulation, error/timeout pulses and idle timer.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    acc_held_d   = acc_held_q;
    pin_d        = pin_q;
    pin_cnt_d    = pin_cnt_q;
    newpin_d     = newpin_q;
    newpin_cnt_d = newpin_cnt_q;
    amt_d        = amt_q;
    op_key_d     = op_key_q;
    lang_d       = lang_q;
    err_d        = 1'b0;
    timeout_d    = 1'b0;
    timer_d      = timer_q;
    clr_all      = 1'b0;

    timer_run = (state_q inside {S_PIN, S_OP, S_AMT, S_NEWPIN}) ||
                ((state_q == S_ACC) && acc_held_q);

    // A key on the would-be timeout edge wins: the abort path is only taken when idle.
    if (bus.key_valid) begin
      timer_d = '0;
    end else if (timer_run) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timer_d   = '0;
        timeout_d = 1'b1;
        clr_all   = 1'b1;
        state_d   = S_ACC;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end

    if (bus.key_valid) begin
      if ((state_q == S_ISSUE) || (bus.key_code >= 4'hE)) begin
        err_d = 1'b1;
      end else if (bus.key_code == KEY_LANG) begin
        if (state_q == S_ACC) lang_d = ~lang_q;
        else                  err_d  = 1'b1;
      end else if (bus.key_code == KEY_CANCEL) begin
        clr_all = 1'b1;
        state_d = S_ACC;
      end else begin
        unique case (state_q)
          S_ACC: begin
            if (is_digit) begin
              acc_d      = bus.key_code;
              acc_held_d = 1'b1;
            end else if (bus.key_code == KEY_CLEAR) begin
              acc_d      = '0;
              acc_held_d = 1'b0;
            end else if (acc_held_q) begin
              state_d = S_PIN;
            end else begin
              err_d = 1'b1;
            end
          end
          S_PIN: begin
            if (is_digit) begin
              if (pin_cnt_q == 3'd4) begin
                err_d = 1'b1;
              end else begin
                pin_d     = (pin_q * 14'd10) + {10'd0, bus.key_code};
                pin_cnt_d = pin_cnt_q + 3'd1;
              end
            end else if (bus.key_code == KEY_CLEAR) begin
              pin_d     = '0;
              pin_cnt_d = '0;
            end else if (pin_cnt_q == 3'd4) begin
              state_d = S_OP;
            end else begin
              err_d = 1'b1;
            end
          end
          S_NEWPIN: begin
            if (is_digit) begin
              if (newpin_cnt_q == 3'd4) begin
                err_d = 1'b1;
              end else begin
                newpin_d     = (newpin_q * 14'd10) + {10'd0, bus.key_code};
                newpin_cnt_d = newpin_cnt_q + 3'd1;
              end
            end else if (bus.key_code == KEY_CLEAR) begin
              newpin_d     = '0;
              newpin_cnt_d = '0;
            end else if (newpin_cnt_q == 3'd4) begin
              state_d = S_ISSUE;
            end else begin
              err_d = 1'b1;
            end
          end
          S_OP: begin
            if (is_digit) begin
              if ((bus.key_code >= 4'd1) && (bus.key_code <= 4'd4)) op_key_d = bus.key_code[2:0];
              else                                                  err_d    = 1'b1;
            end else if (bus.key_code == KEY_CLEAR) begin
              op_key_d = '0;
            end else begin
              unique case (op_key_q)
                3'd1:         state_d = S_ISSUE;
                3'd2, 3'd3:   state_d = S_AMT;
                3'd4:         state_d = S_NEWPIN;
                default:      err_d   = 1'b1;
              endcase
            end
          end
          S_AMT: begin
            if (is_digit) begin
              if (amt_ext > 20'd65535) err_d = 1'b1;
              else                     amt_d = amt_ext[15:0];
            end else if (bus.key_code == KEY_CLEAR) begin
              amt_d = '0;
            end else if (amt_q == 16'd0) begin
              err_d = 1'b1;
            end else begin
              state_d = S_ISSUE;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
    end

    if ((state_q == S_ISSUE) && bus.req_ready) begin
      clr_all = 1'b1;
      state_d = S_ACC;
    end

    if (clr_all) begin
      acc_d        = '0;
      acc_held_d   = 1'b0;
      pin_d        = '0;
      pin_cnt_d    = '0;
      newpin_d     = '0;
      newpin_cnt_d = '0;
      amt_d        = '0;
      op_key_d     = '0;
    end
  end

  // State and field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ACC;
      acc_q        <= '0;
      acc_held_q   <= 1'b0;
      pin_q        <= '0;
      pin_cnt_q    <= '0;
      newpin_q     <= '0;
      newpin_cnt_q <= '0;
      amt_q        <= '0;
      op_key_q     <= '0;
      lang_q       <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      acc_held_q   <= acc_held_d;
      pin_q        <= pin_d;
      pin_cnt_q    <= pin_cnt_d;
      newpin_q     <= newpin_d;
      newpin_cnt_q <= newpin_cnt_d;
      amt_q        <= amt_d;
      op_key_q     <= op_key_d;
      lang_q       <= lang_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
      timer_q      <= timer_d;
    end
  end

  // Map the latched menu key to its operation code.
  always_comb begin
    bus.operation = '0;
    unique case (op_key_q)
      3'd1:    bus.operation = OP_BALANCE;
      3'd2:    bus.operation = OP_WITHDRAW;
      3'd3:    bus.operation = OP_DEPOSIT;
      3'd4:    bus.operation = OP_CHANGE_PIN;
      default: bus.operation = '0;
    endcase
  end

  assign bus.req_valid   = (state_q == S_ISSUE);
  assign bus.acc_num     = acc_q;
  assign bus.pin         = pin_q;
  assign bus.new_pin     = newpin_q;
  assign bus.amount      = amt_q;
  assign bus.language    = lang_q;
  assign bus.err         = err_q;
  assign bus.timeout     = timeout_q;
  assign bus.entry_state = state_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry (TIMEOUT_CYCLES overridden to 8).
module tb_atm_keypad_entry;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp  = 0;
  int n_fail = 0;

  atm_keypad_entry_if bus();

  atm_keypad_entry #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic press_str(input string s);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= "0" && c <= "9") press(4'(c - "0"));
      else                      press(4'(c - "A" + 10));
    end
  endtask

  task automatic handshake;
    @(negedge clk);
    bus.req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_ready = 1'b0;
  endtask

  task automatic test_reset;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.req_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.req_valid, bus.acc_num, bus.pin, bus.new_pin, bus.amount, bus.operation,
         bus.language, bus.err, bus.timeout, bus.entry_state} !== 59'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d acc=%0d pin=%0d amt=%0d op=%0d valid=%0b, required all 0",
               bus.entry_state, bus.acc_num, bus.pin, bus.amount, bus.operation, bus.req_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_balance;
    press_str("7A1234A1");
    n_cmp++;
    if ({bus.req_valid, bus.entry_state} !== {1'b0, 3'd2}) begin
      n_fail++;
      $display("FAIL bal_pre_issue: valid=%0b state=%0d, required valid=0 state=2", bus.req_valid, bus.entry_state);
    end
    press(4'hA);
    n_cmp++;
    if ({bus.req_valid, bus.entry_state, bus.acc_num, bus.pin, bus.operation, bus.amount} !==
        {1'b1, 3'd5, 4'd7, 14'd1234, 3'd3, 16'd0}) begin
      n_fail++;
      $display("FAIL bal_issue: valid=%0b state=%0d acc=%0d pin=%0d op=%0d amt=%0d, required 1 5 7 1234 3 0",
               bus.req_valid, bus.entry_state, bus.acc_num, bus.pin, bus.operation, bus.amount);
    end
    handshake();
    n_cmp++;
    if ({bus.req_valid, bus.entry_state, bus.acc_num, bus.pin, bus.operation} !== 25'd0) begin
      n_fail++;
      $display("FAIL bal_handshake: valid=%0b state=%0d acc=%0d pin=%0d op=%0d, required all 0",
               bus.req_valid, bus.entry_state, bus.acc_num, bus.pin, bus.operation);
    end
  endtask

  task automatic test_amount;
    press_str("2A0009A3A65535A");
    n_cmp++;
    if ({bus.req_valid, bus.acc_num, bus.pin, bus.operation, bus.amount} !==
        {1'b1, 4'd2, 14'd9, 3'd5, 16'd65535}) begin
      n_fail++;
      $display("FAIL amt_max: valid=%0b acc=%0d pin=%0d op=%0d amt=%0d, required 1 2 9 5 65535",
               bus.req_valid, bus.acc_num, bus.pin, bus.operation, bus.amount);
    end
    handshake();
    press_str("2A0009A3A6553");
    press(4'h6);
    n_cmp++;
    if ({bus.err, bus.amount, bus.entry_state} !== {1'b1, 16'd6553, 3'd3}) begin
      n_fail++;
      $display("FAIL amt_overflow: err=%0b amt=%0d state=%0d, required err=1 amt=6553 state=3",
               bus.err, bus.amount, bus.entry_state);
    end
    press(4'hC);
    n_cmp++;
    if ({bus.entry_state, bus.amount, bus.acc_num, bus.operation} !== 26'd0) begin
      n_fail++;
      $display("FAIL amt_cancel: state=%0d amt=%0d acc=%0d op=%0d, required all 0",
               bus.entry_state, bus.amount, bus.acc_num, bus.operation);
    end
  endtask

  task automatic test_pin_length;
    press_str("1A123A");
    n_cmp++;
    if ({bus.err, bus.entry_state} !== {1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL pin_short_enter: err=%0b state=%0d, required err=1 state=1", bus.err, bus.entry_state);
    end
    press(4'h4);
    n_cmp++;
    if ({bus.err, bus.pin} !== {1'b0, 14'd1234}) begin
      n_fail++;
      $display("FAIL pin_4th: err=%0b pin=%0d, required err=0 pin=1234", bus.err, bus.pin);
    end
    press(4'h5);
    n_cmp++;
    if ({bus.err, bus.pin} !== {1'b1, 14'd1234}) begin
      n_fail++;
      $display("FAIL pin_5th: err=%0b pin=%0d, required err=1 pin=1234", bus.err, bus.pin);
    end
    press(4'hA);
    n_cmp++;
    if ({bus.err, bus.entry_state, bus.pin} !== {1'b0, 3'd2, 14'd1234}) begin
      n_fail++;
      $display("FAIL pin_advance: err=%0b state=%0d pin=%0d, required 0 2 1234", bus.err, bus.entry_state, bus.pin);
    end
    press(4'hA);
    n_cmp++;
    if ({bus.err, bus.entry_state} !== {1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL op_enter_none: err=%0b state=%0d, required err=1 state=2", bus.err, bus.entry_state);
    end
    press(4'h7);
    n_cmp++;
    if ({bus.err, bus.operation} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL op_bad_digit: err=%0b op=%0d, required err=1 op=0", bus.err, bus.operation);
    end
    press(4'hC);
  endtask

  task automatic test_illegal_keys;
    press(4'hA);
    n_cmp++;
    if ({bus.err, bus.entry_state} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL acc_enter_empty: err=%0b state=%0d, required err=1 state=0", bus.err, bus.entry_state);
    end
    press(4'hE);
    n_cmp++;
    if ({bus.err, bus.entry_state, bus.acc_num} !== {1'b1, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL key_e: err=%0b state=%0d acc=%0d, required 1 0 0", bus.err, bus.entry_state, bus.acc_num);
    end
    press(4'hD);
    n_cmp++;
    if ({bus.err, bus.language} !== {1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL lang_toggle: err=%0b lang=%0b, required err=0 lang=1", bus.err, bus.language);
    end
    press_str("1A");
    press(4'hD);
    n_cmp++;
    if ({bus.err, bus.language, bus.entry_state} !== {1'b1, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL lang_in_pin: err=%0b lang=%0b state=%0d, required 1 1 1", bus.err, bus.language, bus.entry_state);
    end
    press_str("98B");
    n_cmp++;
    if ({bus.pin, bus.entry_state} !== {14'd0, 3'd1}) begin
      n_fail++;
      $display("FAIL pin_clear: pin=%0d state=%0d, required pin=0 state=1", bus.pin, bus.entry_state);
    end
    press(4'hC);
    n_cmp++;
    if ({bus.entry_state, bus.acc_num, bus.language} !== {3'd0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL cancel_keeps_lang: state=%0d acc=%0d lang=%0b, required 0 0 1",
               bus.entry_state, bus.acc_num, bus.language);
    end
  endtask

  task automatic test_change_pin;
    press_str("3A4321A4A0042A");
    n_cmp++;
    if ({bus.req_valid, bus.acc_num, bus.pin, bus.new_pin, bus.operation, bus.amount} !==
        {1'b1, 4'd3, 14'd4321, 14'd42, 3'd6, 16'd0}) begin
      n_fail++;
      $display("FAIL chg_issue: valid=%0b acc=%0d pin=%0d newpin=%0d op=%0d amt=%0d, required 1 3 4321 42 6 0",
               bus.req_valid, bus.acc_num, bus.pin, bus.new_pin, bus.operation, bus.amount);
    end
    press(4'h5);
    n_cmp++;
    if ({bus.err, bus.req_valid, bus.new_pin} !== {1'b1, 1'b1, 14'd42}) begin
      n_fail++;
      $display("FAIL issue_key: err=%0b valid=%0b newpin=%0d, required 1 1 42", bus.err, bus.req_valid, bus.new_pin);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.req_valid, bus.entry_state, bus.acc_num, bus.pin, bus.new_pin, bus.operation, bus.amount} !==
          {1'b1, 3'd5, 4'd3, 14'd4321, 14'd42, 3'd6, 16'd0}) begin
        n_fail++;
        $display("FAIL chg_hold[%0d]: valid=%0b state=%0d pin=%0d newpin=%0d op=%0d, required 1 5 4321 42 6",
                 i, bus.req_valid, bus.entry_state, bus.pin, bus.new_pin, bus.operation);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.req_valid, bus.acc_num, bus.pin, bus.new_pin, bus.amount, bus.operation,
         bus.language, bus.err, bus.timeout, bus.entry_state} !== 59'd0) begin
      n_fail++;
      $display("FAIL rst_mid_issue: valid=%0b state=%0d acc=%0d pin=%0d newpin=%0d lang=%0b, required all 0",
               bus.req_valid, bus.entry_state, bus.acc_num, bus.pin, bus.new_pin, bus.language);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_timeout;
    press_str("5A");
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL to_early[%0d]: timeout=%0b, required 0", i, bus.timeout);
      end
    end
    press(4'h3);
    n_cmp++;
    if ({bus.timeout, bus.entry_state, bus.pin} !== {1'b0, 3'd1, 14'd3}) begin
      n_fail++;
      $display("FAIL to_key_wins: timeout=%0b state=%0d pin=%0d, required 0 1 3", bus.timeout, bus.entry_state, bus.pin);
    end
    repeat (7) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_7th: timeout=%0b, required 0", bus.timeout);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.timeout, bus.entry_state, bus.acc_num, bus.pin} !== {1'b1, 3'd0, 4'd0, 14'd0}) begin
      n_fail++;
      $display("FAIL to_fire: timeout=%0b state=%0d acc=%0d pin=%0d, required 1 0 0 0",
               bus.timeout, bus.entry_state, bus.acc_num, bus.pin);
    end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.timeout, bus.entry_state} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL to_idle_empty: timeout=%0b state=%0d, required 0 0", bus.timeout, bus.entry_state);
    end
  endtask

  initial begin
    test_reset();
    test_balance();
    test_amount();
    test_pin_length();
    test_illegal_keys();
    test_change_pin();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
